// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and layout helper for the matmul
// operand/result address generators.
package matmul_pkg;

  localparam int DIM      = 16;
  localparam int LOG2_DIM = 4;
  localparam int ELEMS    = 256;

  localparam logic [8:0] A_BASE = 9'h000;
  localparam logic [8:0] B_BASE = 9'h100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tile_state_e;

  // Element offset inside a tile: row-major {outer,inner}, column-major {inner,outer}.
  function automatic logic [2*LOG2_DIM-1:0] tile_offset(
    input logic                mode,
    input logic [LOG2_DIM-1:0] outer,
    input logic [LOG2_DIM-1:0] inner
  );
    logic [2*LOG2_DIM-1:0] off;
    if (mode) begin
      off = {inner, outer};
    end else begin
      off = {outer, inner};
    end
    return off;
  endfunction

endpackage

// File: rtl/tile_index_ctr.sv
// Inner/outer beat counter pair for one DIM x DIM tile plus the
// layout-select offset mux. Shared by the read and write generators.
module tile_index_ctr
  import matmul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  mode,
  output logic [2*LOG2_DIM-1:0] offset,
  output logic                  last
);

  logic [LOG2_DIM-1:0] inner_q, inner_d;
  logic [LOG2_DIM-1:0] outer_q, outer_d;

  // Next counter values: clear wins, otherwise step inner and carry into outer.
  always_comb begin
    inner_d = inner_q;
    outer_d = outer_q;
    if (clr) begin
      inner_d = '0;
      outer_d = '0;
    end else if (inc) begin
      inner_d = inner_q + LOG2_DIM'(1);
      if (inner_q == LOG2_DIM'(DIM - 1)) begin
        outer_d = outer_q + LOG2_DIM'(1);
      end else begin
        outer_d = outer_q;
      end
    end else begin
      inner_d = inner_q;
      outer_d = outer_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign offset = tile_offset(mode, outer_q, inner_q);
  assign last   = (inner_q == LOG2_DIM'(DIM - 1)) && (outer_q == LOG2_DIM'(DIM - 1));

endmodule

// File: rtl/result_writer.sv
// Streams a 16x16 result tile from a valid/ready source into a memory
// write port, one registered write per accepted element, and pulses
// done together with the final write.
module result_writer
  import matmul_pkg::*;
#(
  parameter int                 ADDRLEN = 9,
  parameter int                 DATAW   = 32,
  parameter logic [ADDRLEN-1:0] BASE    = ADDRLEN'(A_BASE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               col_major,
  input  logic               in_valid,
  input  logic [DATAW-1:0]   in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDRLEN-1:0] mem_addr,
  output logic [DATAW-1:0]   mem_wdata,
  output logic               busy,
  output logic               done
);

  tile_state_e          state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 we_q, we_d;
  logic [ADDRLEN-1:0]   addr_q, addr_d;
  logic [DATAW-1:0]     wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 clr_s;
  logic                 accept_s;
  logic                 last_s;
  logic [2*LOG2_DIM-1:0] offset_s;

  assign in_ready = (state_q == RUN);
  assign accept_s = in_valid && in_ready;

  tile_index_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .inc    (accept_s),
    .mode   (mode_q),
    .offset (offset_s),
    .last   (last_s)
  );

  // FSM next state, mode latch and write-port next values.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    clr_s   = 1'b0;
    we_d    = accept_s;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = accept_s && last_s;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = col_major;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      addr_d  = BASE + ADDRLEN'(offset_s);
      wdata_d = in_data;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
    end
  end

  // State, mode and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule
